// File: rtl/led_display_arbiter.sv
// led_display_arbiter
// Time-shares an eight-digit common-anode seven-segment display between two
// requesters. Owns the digit scan, anti-ghost blanking and hex decode, and
// hands ownership over only on frame boundaries with a minimum hold time.

module led_display_arbiter #(
  parameter int SCAN_DIV    = 4096,
  parameter int BLANK       = 16,
  parameter int HOLD_FRAMES = 64
) (
  input  logic        clk_peripheral,
  input  logic        reset,
  input  logic        req0,
  input  logic [39:0] digits0,
  input  logic [7:0]  mask0,
  input  logic        req1,
  input  logic [39:0] digits1,
  input  logic [7:0]  mask1,
  output logic [1:0]  gnt,
  output logic        frame,
  output logic [7:0]  an,
  output logic [7:0]  ca
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HW = $clog2(HOLD_FRAMES + 1);

  localparam logic [CW-1:0] CNT_MAX  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_C  = CW'(BLANK);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    d_q, d_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [39:0]   snap_q, snap_d;
  logic [7:0]    smask_q, smask_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          frame_q, frame_d;
  logic [7:0]    an_q, an_d;
  logic [7:0]    ca_q, ca_d;

  logic          is_e;
  logic [HW-1:0] frames_done;
  logic [2:0]    slot_bit;
  logic          anode_on;
  logic [4:0]    code;

  // Seven-segment decode of a 5-bit code: low nibble is hex, bit 4 lights dp.
  function automatic logic [7:0] decode(input logic [4:0] c);
    logic [7:0] p;
    case (c[3:0])
      4'h0: p = 8'hC0;
      4'h1: p = 8'hF9;
      4'h2: p = 8'hA4;
      4'h3: p = 8'hB0;
      4'h4: p = 8'h99;
      4'h5: p = 8'h92;
      4'h6: p = 8'h82;
      4'h7: p = 8'hF8;
      4'h8: p = 8'h80;
      4'h9: p = 8'h90;
      4'hA: p = 8'h88;
      4'hB: p = 8'h83;
      4'hC: p = 8'hC6;
      4'hD: p = 8'hA1;
      4'hE: p = 8'h86;
      default: p = 8'h8E;
    endcase
    if (c[4]) begin
      p[7] = 1'b0;
    end
    return p;
  endfunction

  // Scan counters: cnt walks through one digit slot, d walks the eight digits.
  always_comb begin
    is_e  = (cnt_q == CNT_MAX) && (d_q == 3'd7);
    cnt_d = cnt_q + CW'(1);
    d_d   = d_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      d_d   = d_q + 3'd1;
    end
    if (is_e) begin
      cnt_d = '0;
      d_d   = 3'd0;
    end
  end

  // Arbitration at frame end; the hold test counts the frame now closing as
  // already shown, so an owner under contention gets exactly HOLD_FRAMES frames.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    snap_d      = snap_q;
    smask_d     = smask_q;
    gnt_d       = gnt_q;
    frame_d     = is_e;
    frames_done = (hold_q >= HOLD_MAX) ? HOLD_MAX : hold_q + HW'(1);

    if (is_e) begin
      case (state_q)
        IDLE: begin
          if (req0) begin
            state_d = OWN0;
          end else if (req1) begin
            state_d = OWN1;
          end
        end
        OWN0: begin
          if (!req0) begin
            state_d = req1 ? OWN1 : IDLE;
          end else if (req1 && (frames_done >= HOLD_MAX)) begin
            state_d = OWN1;
          end
        end
        OWN1: begin
          if (!req1) begin
            state_d = req0 ? OWN0 : IDLE;
          end else if (req0 && (frames_done >= HOLD_MAX)) begin
            state_d = OWN0;
          end
        end
        default: state_d = IDLE;
      endcase

      hold_d = (state_d == state_q) ? frames_done : '0;

      case (state_d)
        OWN0: begin
          snap_d  = digits0;
          smask_d = mask0;
          gnt_d   = 2'b01;
        end
        OWN1: begin
          snap_d  = digits1;
          smask_d = mask1;
          gnt_d   = 2'b10;
        end
        default: begin
          smask_d = 8'h00;
          gnt_d   = 2'b00;
        end
      endcase
    end
  end

  // Pin drive computed from the next scan position so an/ca line up with cnt/d.
  always_comb begin
    slot_bit = 3'd7 - d_d;
    anode_on = (cnt_d >= BLANK_C) && smask_d[slot_bit];
    code     = snap_d[5*slot_bit +: 5];
    an_d     = 8'hFF;
    ca_d     = 8'hFF;
    if (anode_on) begin
      an_d = ~(8'h01 << slot_bit);
      ca_d = decode(code);
    end
  end

  // State register with synchronous reset; everything visible is a flop.
  always_ff @(posedge clk_peripheral) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      d_q     <= 3'd0;
      hold_q  <= '0;
      snap_q  <= '0;
      smask_q <= 8'h00;
      gnt_q   <= 2'b00;
      frame_q <= 1'b0;
      an_q    <= 8'hFF;
      ca_q    <= 8'hFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      hold_q  <= hold_d;
      snap_q  <= snap_d;
      smask_q <= smask_d;
      gnt_q   <= gnt_d;
      frame_q <= frame_d;
      an_q    <= an_d;
      ca_q    <= ca_d;
    end
  end

  assign gnt   = gnt_q;
  assign frame = frame_q;
  assign an    = an_q;
  assign ca    = ca_q;

endmodule
